// File: rtl/eth_header_builder_pkg.sv
// Shared types and constants for the Ethernet header builder.
// The PAD state exists only when ETH_PAD_MIN_FRAME_EN is defined.
package eth_header_builder_pkg;

  localparam logic [15:0] ETHERTYPE_IP  = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam int          HEADER_LEN    = 14;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
`ifdef ETH_PAD_MIN_FRAME_EN
    PAD,
`endif
    GAP
  } state_t;

  // Header byte idx (0 = first on the wire) of {dst MAC, src MAC, EtherType}.
  function automatic logic [7:0] header_byte(input logic [47:0] dst,
                                             input logic [47:0] src,
                                             input logic [15:0] ethertype,
                                             input logic [3:0]  idx);
    logic [111:0] hdr;
    hdr = {dst, src, ethertype} << {idx, 3'b000};
    return hdr[111:104];
  endfunction

endpackage

// File: rtl/eth_ifg_timer.sv
// Loadable down-counter that times the inter-frame gap.
// done is high whenever the count has reached zero.
module eth_ifg_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/eth_header_builder.sv
// Serialises an Ethernet header (dst MAC, src MAC, EtherType) followed by a streamed payload.
// Define ETH_PAD_MIN_FRAME_EN to zero-pad short payloads up to MIN_PAYLOAD bytes.
module eth_header_builder
  import eth_header_builder_pkg::*;
#(
  parameter int IFG_CYCLES  = 12,
  parameter int MAX_PAYLOAD = 1500,
  parameter int MIN_PAYLOAD = 46
) (
  input  logic        clock,
  input  logic        sclr,
  input  logic [47:0] BOARD_MAC,
  input  logic [47:0] PC_MAC,
  input  logic        isIp,
  input  logic        isARP,
  input  logic        start,
  input  logic [7:0]  payload_data,
  input  logic        payload_valid,
  input  logic        payload_last,
  output logic        payload_ready,
  output logic        busy,
  output logic [7:0]  dataout,
  output logic        data_en,
  output logic        data_last,
  output logic        err_type,
  output logic        err_underrun,
  output logic        err_oversize
);

  if (IFG_CYCLES < 1 || MAX_PAYLOAD < 1 || MAX_PAYLOAD > 2047 || MIN_PAYLOAD > MAX_PAYLOAD) begin : g_bad_config
    $error("eth_header_builder: unsupported parameter combination");
  end

  localparam logic [10:0] LAST_IDX = 11'(MAX_PAYLOAD - 1);
  localparam logic [15:0] GAP_LOAD = 16'(IFG_CYCLES - 1);
`ifdef ETH_PAD_MIN_FRAME_EN
  localparam logic [10:0] MIN_COUNT = 11'(MIN_PAYLOAD);
`endif

  state_t      state, state_next;
  logic [3:0]  hdr_cnt, hdr_cnt_next;
  logic [10:0] pay_cnt, pay_cnt_next;
  logic [47:0] dst_mac, dst_next, src_mac, src_next;
  logic        is_arp, is_arp_next;
  logic [7:0]  dataout_next;
  logic        data_en_next, data_last_next;
  logic        err_type_next, err_underrun_next, err_oversize_next;
  logic        timer_load, timer_dec, timer_done;
  logic [15:0] ethertype;

  assign ethertype     = is_arp ? ETHERTYPE_ARP : ETHERTYPE_IP;
  assign busy          = (state != IDLE);
  assign payload_ready = (state == PAYLOAD);

  eth_ifg_timer #(.WIDTH(16)) u_ifg_timer (
    .clock      (clock),
    .sclr       (sclr),
    .load       (timer_load),
    .load_value (GAP_LOAD),
    .dec        (timer_dec),
    .done       (timer_done)
  );

  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      state        <= IDLE;
      hdr_cnt      <= '0;
      pay_cnt      <= '0;
      dst_mac      <= '0;
      src_mac      <= '0;
      is_arp       <= 1'b0;
      dataout      <= 8'h00;
      data_en      <= 1'b0;
      data_last    <= 1'b0;
      err_type     <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_next;
      hdr_cnt      <= hdr_cnt_next;
      pay_cnt      <= pay_cnt_next;
      dst_mac      <= dst_next;
      src_mac      <= src_next;
      is_arp       <= is_arp_next;
      dataout      <= dataout_next;
      data_en      <= data_en_next;
      data_last    <= data_last_next;
      err_type     <= err_type_next;
      err_underrun <= err_underrun_next;
      err_oversize <= err_oversize_next;
    end
  end

  // Byte 0 is produced straight from the inputs at start so the header follows with no bubble.
  always_comb begin
    state_next        = state;
    hdr_cnt_next      = hdr_cnt;
    pay_cnt_next      = pay_cnt;
    dst_next          = dst_mac;
    src_next          = src_mac;
    is_arp_next       = is_arp;
    dataout_next      = 8'h00;
    data_en_next      = 1'b0;
    data_last_next    = 1'b0;
    err_type_next     = 1'b0;
    err_underrun_next = 1'b0;
    err_oversize_next = 1'b0;
    timer_load        = 1'b0;
    timer_dec         = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (isIp ^ isARP) begin
            state_next   = HEADER;
            dst_next     = PC_MAC;
            src_next     = BOARD_MAC;
            is_arp_next  = isARP;
            dataout_next = PC_MAC[47:40];
            data_en_next = 1'b1;
            hdr_cnt_next = 4'd1;
            pay_cnt_next = '0;
          end else begin
            err_type_next = 1'b1;
          end
        end
      end

      HEADER: begin
        dataout_next = header_byte(dst_mac, src_mac, ethertype, hdr_cnt);
        data_en_next = 1'b1;
        if (hdr_cnt == 4'(HEADER_LEN - 1)) begin
          state_next   = PAYLOAD;
          hdr_cnt_next = '0;
        end else begin
          hdr_cnt_next = hdr_cnt + 4'd1;
        end
      end

      PAYLOAD: begin
        if (payload_valid) begin
          dataout_next = payload_data;
          data_en_next = 1'b1;
          pay_cnt_next = pay_cnt + 11'd1;
          if (payload_last || (pay_cnt == LAST_IDX)) begin
            err_oversize_next = !payload_last;
`ifdef ETH_PAD_MIN_FRAME_EN
            if (pay_cnt_next < MIN_COUNT) begin
              state_next = PAD;
            end else begin
              state_next     = GAP;
              data_last_next = 1'b1;
              timer_load     = 1'b1;
            end
`else
            state_next     = GAP;
            data_last_next = 1'b1;
            timer_load     = 1'b1;
`endif
          end
        end else begin
          state_next        = GAP;
          err_underrun_next = 1'b1;
          timer_load        = 1'b1;
        end
      end

`ifdef ETH_PAD_MIN_FRAME_EN
      PAD: begin
        data_en_next = 1'b1;
        pay_cnt_next = pay_cnt + 11'd1;
        if (pay_cnt_next == MIN_COUNT) begin
          state_next     = GAP;
          data_last_next = 1'b1;
          timer_load     = 1'b1;
        end
      end
`endif

      // The cycle still carrying the final byte does not count toward the gap.
      GAP: begin
        if (!data_en) begin
          if (timer_done) begin
            state_next = IDLE;
          end else begin
            timer_dec = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
